// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between P_NUM_REQ requesters.
// Owners stay locked until a byte flagged last completes; busy-rise has a watchdog.
module uart_tx_arb #(
  parameter int P_NUM_REQ = 4,
  parameter int P_BUSY_TO = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [P_NUM_REQ-1:0]   i_req_vld,
  input  logic [8*P_NUM_REQ-1:0] i_req_dat,
  input  logic [P_NUM_REQ-1:0]   i_req_last,
  output logic [P_NUM_REQ-1:0]   o_req_rdy,
  output logic                   o_tx_vld,
  output logic [7:0]             o_tx_dat,
  input  logic                   i_tx_busy,
  output logic [P_NUM_REQ-1:0]   o_grant,
  output logic                   o_err
);
  localparam int IW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
  localparam int SW = IW + 1;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;
  localparam logic [7:0] WD_LAST      = 8'(P_BUSY_TO - 1);

  logic [P_NUM_REQ-1:0][7:0] req_dat;
  for (genvar gi = 0; gi < P_NUM_REQ; gi++) begin : g_unpack
    assign req_dat[gi] = i_req_dat[8*gi +: 8];
  end

  logic [1:0]           state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d, own_q, own_d;
  logic                 lock_q, lock_d, last_q, last_d;
  logic [7:0]           wd_q, wd_d, wd_inc;
  logic [P_NUM_REQ-1:0] rdy_q, rdy_d, grant_q, grant_d;
  logic                 tx_vld_q, tx_vld_d, err_q, err_d;
  logic [7:0]           tx_dat_q, tx_dat_d;

  // Rotating search: first valid requester at or above the pointer, wrapping.
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [SW-1:0] sum;
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + SW'(i);
      if (sum >= SW'(P_NUM_REQ)) sum = sum - SW'(P_NUM_REQ);
      if (!sel_found && i_req_vld[sum[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = sum[IW-1:0];
      end
    end
  end

  // While locked only the owner may be taken; others are starved.
  logic          take;
  logic [IW-1:0] take_idx;
  always_comb begin
    take     = 1'b0;
    take_idx = own_q;
    if (state_q == ST_IDLE) begin
      if (lock_q) begin
        take = i_req_vld[own_q];
      end else if (sel_found) begin
        take     = 1'b1;
        take_idx = sel_idx;
      end
    end
  end

  logic [IW-1:0] own_nxt;
  assign own_nxt = (own_q == IW'(P_NUM_REQ - 1)) ? '0 : own_q + IW'(1);
  assign wd_inc  = wd_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    lock_d   = lock_q;
    last_d   = last_q;
    wd_d     = wd_q;
    rdy_d    = '0;
    tx_vld_d = 1'b0;
    tx_dat_d = tx_dat_q;
    grant_d  = grant_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          own_d             = take_idx;
          last_d            = i_req_last[take_idx];
          tx_vld_d          = 1'b1;
          tx_dat_d          = req_dat[take_idx];
          rdy_d[take_idx]   = 1'b1;
          grant_d           = '0;
          grant_d[take_idx] = 1'b1;
          state_d           = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (wd_inc == WD_LAST) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          grant_d = '0;
          ptr_d   = own_nxt;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
          state_d = ST_IDLE;
          if (last_q) begin
            lock_d  = 1'b0;
            grant_d = '0;
            ptr_d   = own_nxt;
          end else begin
            lock_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      own_q    <= '0;
      lock_q   <= 1'b0;
      last_q   <= 1'b0;
      wd_q     <= '0;
      rdy_q    <= '0;
      tx_vld_q <= 1'b0;
      tx_dat_q <= 8'h00;
      grant_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      own_q    <= own_d;
      lock_q   <= lock_d;
      last_q   <= last_d;
      wd_q     <= wd_d;
      rdy_q    <= rdy_d;
      tx_vld_q <= tx_vld_d;
      tx_dat_q <= tx_dat_d;
      grant_q  <= grant_d;
      err_q    <= err_d;
    end
  end

  assign o_req_rdy = rdy_q;
  assign o_tx_vld  = tx_vld_q;
  assign o_tx_dat  = tx_dat_q;
  assign o_grant   = grant_q;
  assign o_err     = err_q;
endmodule
